// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS control path:
// opcode/funct encodings, controller state enum, alu_op enum and ALU codes.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALUC_AND   = 3'b000;
  localparam logic [ALUC_W-1:0] ALUC_OR    = 3'b001;
  localparam logic [ALUC_W-1:0] ALUC_ADD   = 3'b010;
  localparam logic [ALUC_W-1:0] ALUC_UNDEF = 3'b011;
  localparam logic [ALUC_W-1:0] ALUC_SUB   = 3'b110;
  localparam logic [ALUC_W-1:0] ALUC_SLT   = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } ctrl_state_t;

  // ADD is the zero encoding so states that do not use the ALU default to it.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the controller's alu_op (and funct for R-type) to the
// 3-bit alu_control code.
//   alu_op      : ADD / SUB / FUNCT request from the main FSM
//   funct       : instruction[5:0]
//   alu_control : ALU operation code
module alu_decoder
  import mips_pkg::*;
(
  input  alu_op_t            alu_op,
  input  logic [5:0]         funct,
  output logic [2:0]         alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    unique case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        unique case (funct)
          FUNCT_ADD: alu_control = ALUC_ADD;
          FUNCT_SUB: alu_control = ALUC_SUB;
          FUNCT_AND: alu_control = ALUC_AND;
          FUNCT_OR:  alu_control = ALUC_OR;
          FUNCT_SLT: alu_control = ALUC_SLT;
          default:   alu_control = ALUC_UNDEF;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control unit of the multicycle MIPS datapath. Moore FSM stepping
// each instruction through fetch/decode/execute/memory/writeback.
//   clk, reset_n      : clock, synchronous active-low reset
//   op, funct         : opcode and funct fields held in the IR
//   zero              : ALU zero flag (used only for beq)
//   iord .. pc_src    : datapath selects and write enables
//   pc_en             : pc_write | (branch & zero)
//   illegal_op        : pulse in DECODE for an unsupported opcode
//   state             : current FSM state for debug
module mips_multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  ctrl_state_t state_q;
  ctrl_state_t next_state;
  ctrl_state_t cur_state;
  alu_op_t     alu_op;
  logic        pc_write;
  logic        branch;
  logic        mem_write_raw;
  logic        ir_write_raw;
  logic        reg_write_raw;
  logic        illegal_raw;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= next_state;
  end

  // While in reset the outputs decode as FETCH regardless of the register.
  assign cur_state = reset_n ? state_q : S_FETCH;
  assign state     = cur_state;

  // Next-state logic.
  always_comb begin
    next_state = S_FETCH;
    unique case (state_q)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEXEC;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ADDIEXEC: next_state = S_ADDIWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // Moore output decode.
  always_comb begin
    iord          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALUOP_ADD;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    branch        = 1'b0;
    illegal_raw   = 1'b0;
    unique case (cur_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b01;
        pc_write     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        illegal_raw = !op_supported(op);
      end
      S_MEMADR, S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWRITE: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = 2'b01;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are suppressed outright during reset.
  assign mem_write  = mem_write_raw & reset_n;
  assign ir_write   = ir_write_raw & reset_n;
  assign reg_write  = reg_write_raw & reset_n;
  assign illegal_op = illegal_raw & reset_n;
  assign pc_en      = (pc_write | (branch & zero)) & reset_n;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  mips_multicycle_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .iord        (iord),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  always #5 clk = ~clk;

  // One expected cycle of control; acare=0 means the ALU code is unspecified.
  typedef struct packed {
    logic       iord, mw, irw, rd, m2r, rw, asa;
    logic [1:0] asb;
    logic [2:0] ac;
    logic       acare;
    logic [1:0] psrc;
    logic       pcw, br, ill;
  } exp_t;

  function automatic exp_t mk(input logic iord_i, mw, irw, rd, m2r, rw, asa,
                              input logic [1:0] asb, input logic [2:0] ac,
                              input logic acare, input logic [1:0] psrc,
                              input logic pcw, br, ill);
    exp_t e;
    e = '{iord_i, mw, irw, rd, m2r, rw, asa, asb, ac, acare, psrc, pcw, br, ill};
    return e;
  endfunction

  function automatic logic known_op(input logic [5:0] o);
    logic [5:0] ops [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    foreach (ops[k]) if (ops[k] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] funct_code(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b011;
    endcase
  endfunction

  // Runs one instruction from FETCH; zm: 0/1 force zero, 2 random.
  // rst_at >= 0 asserts reset in that cycle and abandons the instruction.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zm, input int rst_at);
    exp_t q[$];
    exp_t e;
    logic z;
    logic [15:0] ov, ev;
    q.push_back(mk(0,0,1,0,0,0,0,2'b01,3'b010,1,2'b00,1,0,0));
    q.push_back(mk(0,0,0,0,0,0,0,2'b11,3'b010,1,2'b00,0,0,!known_op(o)));
    case (o)
      6'b100011: begin
        q.push_back(mk(0,0,0,0,0,0,1,2'b10,3'b010,1,2'b00,0,0,0));
        q.push_back(mk(1,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,0));
        q.push_back(mk(0,0,0,0,1,1,0,2'b00,3'b000,0,2'b00,0,0,0));
      end
      6'b101011: begin
        q.push_back(mk(0,0,0,0,0,0,1,2'b10,3'b010,1,2'b00,0,0,0));
        q.push_back(mk(1,1,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,0));
      end
      6'b000000: begin
        q.push_back(mk(0,0,0,0,0,0,1,2'b00,funct_code(f),1,2'b00,0,0,0));
        q.push_back(mk(0,0,0,1,0,1,0,2'b00,3'b000,0,2'b00,0,0,0));
      end
      6'b000100:
        q.push_back(mk(0,0,0,0,0,0,1,2'b00,3'b110,1,2'b01,0,1,0));
      6'b001000: begin
        q.push_back(mk(0,0,0,0,0,0,1,2'b10,3'b010,1,2'b00,0,0,0));
        q.push_back(mk(0,0,0,0,0,1,0,2'b00,3'b000,0,2'b00,0,0,0));
      end
      6'b000010:
        q.push_back(mk(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b10,1,0,0));
      default: ;
    endcase
    foreach (q[i]) begin
      op    = o;
      funct = f;
      z     = (zm == 2) ? 1'($urandom_range(0, 1)) : (zm == 1);
      zero  = z;
      e     = q[i];
      if (i == rst_at) begin
        reset_n = 1'b0;
        // Reset view: FETCH selects, all write enables off.
        e = mk(0,0,0,0,0,0,0,2'b01,3'b010,1,2'b00,0,0,0);
      end
      @(negedge clk);
      ev = {e.iord, e.mw, e.irw, e.rd, e.m2r, e.rw, e.asa, e.asb,
            e.acare ? e.ac : 3'b000, e.psrc, e.pcw | (e.br & z), e.ill};
      ov = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
            alu_src_b, e.acare ? alu_control : 3'b000, pc_src, pc_en, illegal_op};
      n_cmp++;
      assert (ov === ev) else begin
        n_err++;
        $error("FAIL ctl op=%b funct=%b cyc=%0d obs=%b exp=%b", o, f, i + 1, ov, ev);
      end
      n_cmp++;
      assert ((state === 4'd0) === (i == 0 || i == rst_at)) else begin
        n_err++;
        $error("FAIL state_fetch op=%b cyc=%0d obs_state=%0d exp_fetch=%0d",
               o, i + 1, state, (i == 0 || i == rst_at));
      end
      @(posedge clk);
      #1;
      if (i == rst_at) begin
        reset_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [5:0] functs [6];
    logic [5:0] o, f;
    int sel;
    functs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    reset_n = 1'b0;
    op      = 6'b100011;
    funct   = 6'b0;
    zero    = 1'b1;

    // Reset state: FETCH selects visible, enables forced low.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      assert ({state, ir_write, pc_en, reg_write, mem_write, illegal_op, alu_src_b, alu_control}
              === {4'd0, 5'b00000, 2'b01, 3'b010}) else begin
        n_err++;
        $error("FAIL reset obs=%b", {state, ir_write, pc_en, reg_write, mem_write,
               illegal_op, alu_src_b, alu_control});
      end
      @(posedge clk);
    end
    #1;
    reset_n = 1'b1;

    // Directed steps.
    run_instr(6'b100011, 6'b0, 2, -1);                   // lw
    run_instr(6'b101011, 6'b0, 2, -1);                   // sw
    foreach (functs[k]) run_instr(6'b000000, functs[k], 2, -1);
    run_instr(6'b000100, 6'b0, 1, -1);                   // beq taken
    run_instr(6'b000100, 6'b0, 0, -1);                   // beq not taken
    run_instr(6'b001000, 6'b0, 2, -1);                   // addi
    run_instr(6'b000010, 6'b0, 2, -1);                   // j
    run_instr(6'b111111, 6'b0, 2, -1);                   // unsupported
    run_instr(6'b100011, 6'b0, 2, 3);                    // reset in MEMREAD
    run_instr(6'b101011, 6'b0, 2, -1);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 6);
      f   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
      case (sel)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        default: begin
          o = 6'($urandom);
          while (known_op(o)) o = 6'($urandom);
        end
      endcase
      run_instr(o, f, 2, ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
